// File: rtl/regfile_pkg.sv
// Shared types for the register-file write path.
//   DATA_W / ADDR_W : default write-data and register-index widths
//   wr_req_t        : one queued register write {rd, data}
//   grant_t         : arbitration outcome for the single write port
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_WB    = 2'd1,
        GNT_DRAIN = 2'd2,
        GNT_FORCE = 2'd3
    } grant_t;

endpackage

// File: rtl/wr_req_fifo.sv
// Small synchronous FIFO holding long-latency-unit write requests.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears pointers/count)
//   push        : write push_data at the tail (ignored when full)
//   push_data   : request to enqueue
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry, valid when !empty
//   full, empty : occupancy flags from the registered count
module wr_req_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// writeback stage (WB, priority) and the long-latency unit (LU, buffered).
// A starvation counter forces an LU grant after MAX_WAIT lost cycles.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data      : WB write request
//   wb_ready                    : WB request accepted this cycle
//   lu_valid/lu_rd/lu_data      : LU result to enqueue
//   lu_ready                    : FIFO can accept
//   rf_we/rf_rd/rf_wdata        : registered register-file write port
//   lu_pending                  : FIFO non-empty (hazard/stall logic)
module regfile_write_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              lu_pending
);

    import regfile_pkg::*;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    wr_req_t    push_req;
    wr_req_t    head_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       force_drain;
    logic [3:0] wait_cnt;
    grant_t     gnt_p0;

    assign push_req = '{rd: lu_rd, data: lu_data};

    // A full FIFO refuses a push even when it pops in the same cycle,
    // which keeps lu_ready independent of the grant decision.
    assign lu_ready = !reset && !fifo_full;
    assign push     = lu_valid && lu_ready;

    wr_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---- stage p0: grant selection ----
    assign force_drain = !fifo_empty && (wait_cnt >= WAIT_LIMIT);

    always_comb begin
        gnt_p0 = GNT_IDLE;
        if (force_drain)      gnt_p0 = GNT_FORCE;
        else if (wb_valid)    gnt_p0 = GNT_WB;
        else if (!fifo_empty) gnt_p0 = GNT_DRAIN;
    end

    assign wb_ready   = !reset && !force_drain;
    assign pop        = !reset && ((gnt_p0 == GNT_FORCE) || (gnt_p0 == GNT_DRAIN));
    assign lu_pending = !fifo_empty;

    // Counts consecutive cycles a queued entry lost to WB; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else if ((gnt_p0 == GNT_WB) && (wait_cnt < WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ---- stage p1: registered write port ----
    // Writes to x0 still consume the grant but never assert rf_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            case (gnt_p0)
                GNT_WB: begin
                    rf_we    <= (wb_rd != '0);
                    rf_rd    <= wb_rd;
                    rf_wdata <= wb_data;
                end
                GNT_FORCE, GNT_DRAIN: begin
                    rf_we    <= (head_req.rd != '0);
                    rf_rd    <= head_req.rd;
                    rf_wdata <= head_req.data;
                end
                default: begin
                    rf_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (defaults:
// DATA_W=64, ADDR_W=5, FIFO_DEPTH=2, MAX_WAIT=4). Inputs change 1 ns after
// the rising edge; outputs are sampled there too, away from the edge.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [63:0] lu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic        lu_pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W     (64),
        .ADDR_W     (5),
        .FIFO_DEPTH (2),
        .MAX_WAIT   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .lu_pending (lu_pending)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [63:0] data);
        check({tag, "_we"}, 64'(rf_we), 64'd1);
        check({tag, "_rd"}, 64'(rf_rd), 64'(rd));
        check({tag, "_data"}, rf_wdata, data);
    endtask

    initial begin
        reset    = 1'b1;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        lu_valid = 1'b0;
        lu_rd    = '0;
        lu_data  = '0;

        // Reset state
        tick();
        tick();
        check("rst_wb_ready", 64'(wb_ready), 64'd0);
        check("rst_lu_ready", 64'(lu_ready), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_rd", 64'(rf_rd), 64'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        check("rst_pending", 64'(lu_pending), 64'd0);
        reset = 1'b0;
        #1;
        check("idle_wb_ready", 64'(wb_ready), 64'd1);
        check("idle_lu_ready", 64'(lu_ready), 64'd1);
        tick();
        check("post_rst_we", 64'(rf_we), 64'd0);

        // WB only
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'hAB;
        #1;
        check("wb_ready_c0", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check_write("wb_only", 5'd3, 64'hAB);
        check("wb_ready_c1", 64'(wb_ready), 64'd1);
        tick();
        check("wb_only_idle_we", 64'(rf_we), 64'd0);

        // LU only
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'd42;
        #1;
        check("lu_ready_c0", 64'(lu_ready), 64'd1);
        tick();
        lu_valid = 1'b0;
        check("lu_pending_c1", 64'(lu_pending), 64'd1);
        check("lu_no_bypass_we", 64'(rf_we), 64'd0);
        tick();
        check_write("lu_only", 5'd7, 64'd42);
        check("lu_pending_c2", 64'(lu_pending), 64'd0);
        tick();

        // Starvation: entry queued in cycle 0, WB asserted continuously
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h99;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h100;
        tick();
        lu_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("starve_wb_write", rf_wdata, 64'h100 + 64'(c - 1));
            wb_data = 64'h100 + 64'(c);
            #1;
            check("starve_wb_ready", 64'(wb_ready), 64'd1);
            tick();
        end
        check("starve_wb_write4", rf_wdata, 64'h104);
        wb_data = 64'h105;
        #1;
        check("force_wb_ready", 64'(wb_ready), 64'd0);
        tick();
        check_write("force_lu", 5'd9, 64'h99);
        check("force_pending", 64'(lu_pending), 64'd0);
        check("resume_wb_ready", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check_write("resume_wb", 5'd1, 64'h105);
        tick();

        // Full FIFO under continuous WB; order preserved
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 64'h200;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 64'hA0;
        #1;
        check("full_lu_ready_c0", 64'(lu_ready), 64'd1);
        tick();
        lu_rd = 5'd11; lu_data = 64'hB0;
        #1;
        check("full_lu_ready_c1", 64'(lu_ready), 64'd1);
        tick();
        lu_rd = 5'd12; lu_data = 64'hC0;
        #1;
        check("full_lu_ready_c2", 64'(lu_ready), 64'd0);
        tick();
        tick();
        tick();
        check("full_force_wb_ready", 64'(wb_ready), 64'd0);
        check("full_force_lu_ready", 64'(lu_ready), 64'd0);
        tick();
        check_write("full_first", 5'd10, 64'hA0);
        check("full_lu_ready_c6", 64'(lu_ready), 64'd1);
        tick();
        lu_valid = 1'b0;
        tick();
        tick();
        tick();
        check("full_force2_wb_ready", 64'(wb_ready), 64'd0);
        tick();
        check_write("full_second", 5'd11, 64'hB0);
        wb_valid = 1'b0;
        tick();
        check_write("full_third", 5'd12, 64'hC0);
        check("full_pending_end", 64'(lu_pending), 64'd0);
        tick();

        // x0 writes
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        #1;
        check("x0_wb_ready", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check("x0_wb_we", 64'(rf_we), 64'd0);
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 64'h55;
        tick();
        lu_valid = 1'b0;
        check("x0_lu_pending", 64'(lu_pending), 64'd1);
        tick();
        check("x0_lu_we", 64'(rf_we), 64'd0);
        check("x0_lu_popped", 64'(lu_pending), 64'd0);
        tick();

        // Reset mid-operation with two queued entries
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h400;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 64'hD0;
        tick();
        lu_rd = 5'd21; lu_data = 64'hE0;
        tick();
        lu_valid = 1'b0;
        check("mid_pending", 64'(lu_pending), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_wb_ready", 64'(wb_ready), 64'd0);
        check("mid_rst_lu_ready", 64'(lu_ready), 64'd0);
        tick();
        reset = 1'b0;
        wb_valid = 1'b0;
        check("mid_rst_pending", 64'(lu_pending), 64'd0);
        check("mid_rst_we", 64'(rf_we), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale_write", 64'(rf_we), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
